// File: rtl/func_as_pkg.sv
// Shared constants for the Func_AS command sequencer: widths, opcodes, FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package func_as_pkg;

    localparam int FAS_DATA_W = 4;
    localparam int FAS_OP_W   = 3;

    // Command opcodes
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_INCN = 3'd4;
    localparam logic [2:0] OP_DECN = 3'd5;
    localparam logic [2:0] OP_READ = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/func_as.sv
// 4-bit add/sub/inc/dec arithmetic unit (Add: a+b, Sub: b-a, Inc: b+1, else b-1, mod 2^W).
// Latency: purely combinational.
// Backpressure: none; result follows inputs.
module func_as #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              add,
    input  logic              sub,
    input  logic              inc,
    input  logic              switch,
    output logic [DATA_W-1:0] c
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;

    // Switch swaps the operand roles; priority Add > Sub > Inc > Dec
    always_comb begin
        x = a;
        y = b;
        if (switch) begin
            x = b;
            y = a;
        end
        if (add)      c = x + y;
        else if (sub) c = y - x;
        else if (inc) c = y + ONE;
        else          c = y - ONE;
    end

endmodule

// File: rtl/func_as_sequencer.sv
// Command sequencer owning a W-bit accumulator, driving the Func_AS unit one step per EXEC cycle.
// Latency: LOAD/CLR/READ/zero-count 1 cycle, ADD/SUB 2 cycles, INCN/DECN N -> N+1 cycles.
// Backpressure: one command in flight; cmd_ready low until the response is taken (res_ready).
module func_as_sequencer
    import func_as_pkg::*;
#(
    parameter int DATA_W = FAS_DATA_W,
    parameter int OP_W   = FAS_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_add,
    output logic              alu_sub,
    output logic              alu_inc,
    output logic              alu_switch,
    input  logic [DATA_W-1:0] alu_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_wrap,
    output logic              busy
);

    localparam logic [DATA_W-1:0] CNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              wrap_q, wrap_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_zero_q, res_zero_d;
    logic              res_wrap_q, res_wrap_d;
    logic              exec;
    logic              iter_wrap;

    assign exec       = (state_q == ST_EXEC);
    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign res_valid  = (state_q == ST_RESP);
    assign res_data   = res_data_q;
    assign res_zero   = res_zero_q;
    assign res_wrap   = res_wrap_q;
    assign alu_a      = opnd_q;
    assign alu_b      = acc_q;
    assign alu_add    = exec && (op_q == OP_ADD);
    assign alu_sub    = exec && (op_q == OP_SUB);
    assign alu_inc    = exec && (op_q == OP_INCN);
    assign alu_switch = 1'b0;

    // Modulo wrap/borrow detection for the step currently being executed
    always_comb begin
        iter_wrap = 1'b0;
        case (op_q)
            OP_ADD:  iter_wrap = (alu_c < opnd_q);
            OP_SUB:  iter_wrap = (opnd_q > acc_q);
            OP_INCN: iter_wrap = (acc_q == {DATA_W{1'b1}});
            OP_DECN: iter_wrap = (acc_q == '0);
            default: iter_wrap = 1'b0;
        endcase
    end

    // Command accept, iteration and response handshake
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        wrap_d  = wrap_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    opnd_d = cmd_data;
                    wrap_d = 1'b0;
                    case (cmd_op)
                        OP_LOAD: begin
                            acc_d   = cmd_data;
                            state_d = ST_RESP;
                        end
                        OP_CLR: begin
                            acc_d   = '0;
                            state_d = ST_RESP;
                        end
                        OP_READ: state_d = ST_RESP;
                        OP_ADD, OP_SUB: begin
                            cnt_d   = CNT_ONE;
                            state_d = ST_EXEC;
                        end
                        OP_INCN, OP_DECN: begin
                            if (cmd_data == '0) begin
                                state_d = ST_RESP;
                            end else begin
                                cnt_d   = cmd_data;
                                state_d = ST_EXEC;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_EXEC: begin
                acc_d  = alu_c;
                cnt_d  = cnt_q - CNT_ONE;
                wrap_d = wrap_q | iter_wrap;
                if (cnt_q == CNT_ONE) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Snapshot the response when entering RESP so it stays stable under backpressure
    always_comb begin
        res_data_d = res_data_q;
        res_zero_d = res_zero_q;
        res_wrap_d = res_wrap_q;
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            res_data_d = acc_d;
            res_zero_d = (acc_d == '0);
            res_wrap_d = wrap_d;
        end
    end

    // State registers; reset drops any in-flight command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            wrap_q     <= 1'b0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            res_wrap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            wrap_q     <= wrap_d;
            res_data_q <= res_data_d;
            res_zero_q <= res_zero_d;
            res_wrap_q <= res_wrap_d;
        end
    end

endmodule

// File: tb/tb_func_as_sequencer.sv
// Directed bench: sequencer plus arithmetic unit, hand-computed expected responses and latencies.
// Latency: measured in cycles from the accepting edge.
// Backpressure: exercised by holding res_ready low while a new command is offered.
module tb_func_as_sequencer;
    import func_as_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] alu_a, alu_b, alu_c;
    logic       alu_add, alu_sub, alu_inc, alu_switch;
    logic       res_valid, res_ready;
    logic [3:0] res_data;
    logic       res_zero, res_wrap;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    func_as_sequencer #(.DATA_W(4), .OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_add(alu_add), .alu_sub(alu_sub),
        .alu_inc(alu_inc), .alu_switch(alu_switch), .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_wrap(res_wrap), .busy(busy)
    );

    func_as #(.DATA_W(4)) u_unit (
        .a(alu_a), .b(alu_b), .add(alu_add), .sub(alu_sub),
        .inc(alu_inc), .switch(alu_switch), .c(alu_c)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Issue one command (called #1 after an edge); returns latency and EXEC cycles with alu_inc high
    task automatic do_cmd(input logic [2:0] op, input logic [3:0] d, output int lat, output int incs);
        int guard;
        guard = 0;
        lat   = 0;
        incs  = 0;
        while (!cmd_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 40) begin
            if (alu_inc) incs++;
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid) chk("resp_timeout", int'(res_valid), 1);
    endtask

    task automatic take_resp();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [3:0] d,
                       input int e_data, input int e_zero, input int e_wrap, input int e_lat);
        int lat, incs;
        do_cmd(op, d, lat, incs);
        chk({tag, "_lat"},  lat, e_lat);
        chk({tag, "_data"}, int'(res_data), e_data);
        chk({tag, "_zero"}, int'(res_zero), e_zero);
        chk({tag, "_wrap"}, int'(res_wrap), e_wrap);
        take_resp();
    endtask

    initial begin
        int lat, incs;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = 4'd0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_acc",       int'(alu_b), 0);
        chk("rst_res_data",  int'(res_data), 0);
        chk("rst_res_wrap",  int'(res_wrap), 0);
        chk("rst_switch",    int'(alu_switch), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add
        run("load5", OP_LOAD, 4'd5, 5, 0, 0, 1);
        run("add3",  OP_ADD,  4'd3, 8, 0, 0, 2);

        // Borrow then wrap to zero, flag sticky per command
        run("load2", OP_LOAD, 4'd2, 2, 0, 0, 1);
        run("sub5",  OP_SUB,  4'd5, 13, 0, 1, 2);
        run("add3w", OP_ADD,  4'd3, 0, 1, 1, 2);

        // INCN across 15 -> 0, count EXEC cycles with alu_inc
        run("load14", OP_LOAD, 4'd14, 14, 0, 0, 1);
        do_cmd(OP_INCN, 4'd3, lat, incs);
        chk("incn3_lat",  lat, 4);
        chk("incn3_incs", incs, 3);
        chk("incn3_data", int'(res_data), 1);
        chk("incn3_wrap", int'(res_wrap), 1);
        take_resp();
        run("decn0", OP_DECN, 4'd0, 1, 0, 0, 1);
        run("decn2", OP_DECN, 4'd2, 15, 0, 1, 3);
        run("clr",   OP_CLR,  4'd9, 0, 1, 0, 1);
        run("load1", OP_LOAD, 4'd1, 1, 0, 0, 1);

        // Backpressure: response held, new command ignored
        do_cmd(OP_READ, 4'd0, lat, incs);
        chk("read_lat", lat, 1);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 4'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", int'(res_valid), 1);
            chk("hold_data",  int'(res_data), 1);
            chk("hold_ready", int'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        take_resp();
        chk("hold_acc", int'(alu_b), 1);

        // NOP with consumer ready: no response, still ready
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_NOP;
        cmd_data  = 4'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("nop_valid", int'(res_valid), 0);
            chk("nop_ready", int'(cmd_ready), 1);
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        run("read_nop", OP_READ, 4'd0, 1, 0, 0, 1);

        // Asynchronous reset in the middle of INCN 10
        cmd_valid = 1'b1;
        cmd_op    = OP_INCN;
        cmd_data  = 4'd10;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", int'(busy), 1);
        chk("mid_acc",  int'(alu_b), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(res_valid), 0);
        chk("arst_busy",  int'(busy), 0);
        chk("arst_acc",   int'(alu_b), 0);
        chk("arst_inc",   int'(alu_inc), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run("read_rst", OP_READ, 4'd0, 0, 1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
